hazard_stall_ctrl: RTL
======================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter MAX_STALL, default 8, SHALL set the consecutive hazard-stall cycles that trip the timeout.
REQ-002 Parameter CNT_W, default 16, SHALL set the statistics counter width.
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hazard_Detected  in  1  RAW hazard request from ID.
- branch_taken  in  1  taken-branch pulse from EXE.
- mem_ready  in  1  0 = memory stage busy, whole pipeline must hold.
- freeze_pc  out  1  hold PC.
- freeze_if_id  out  1  hold IF/ID register.
- flush_if_id  out  1  clear IF/ID to NOP.
- bubble_id_ex  out  1  zero ID/EX control bits.
- freeze_pipe  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_timeout  out  1  sticky hazard-deadlock flag.
- state_o  out  2  FSM state.
- hazard_cnt, memwait_cnt, flush_cnt  out  CNT_W each  statistics (REQ-016).

Function
REQ-004 FSM states SHALL be RUN=2'b00, MEM_WAIT=2'b01 and MEM_WAIT_BR=2'b10; 2'b11 SHALL go to RUN on the next edge with all outputs 0.
REQ-005 Control outputs SHALL be combinational from the state and the current inputs, with zero-cycle latency.
REQ-006 Priority within any cycle SHALL be: mem stall, then branch flush, then hazard stall.
REQ-007 Any state with mem_ready=0 SHALL drive freeze_pc, freeze_if_id and freeze_pipe to 1 and flush_if_id and bubble_id_ex to 0.
- Next state SHALL be MEM_WAIT_BR if branch_taken=1 or the state is already MEM_WAIT_BR.
- Otherwise next state SHALL be MEM_WAIT.
REQ-008 Branch flush in RUN/MEM_WAIT (mem_ready=1, branch_taken=1) SHALL drive flush_if_id=1 and bubble_id_ex=1, with all freezes 0.
REQ-009 Hazard stall in RUN/MEM_WAIT (mem_ready=1, branch_taken=0, hazard_Detected=1) SHALL drive freeze_pc=1, freeze_if_id=1 and bubble_id_ex=1, with flush_if_id=0 and freeze_pipe=0.
REQ-010 MEM_WAIT_BR with mem_ready=1 SHALL perform the branch flush of REQ-008 whatever the value of branch_taken, then go to RUN.
REQ-011 MEM_WAIT with mem_ready=1 SHALL apply RUN logic that cycle and go to RUN.
REQ-012 A branch arriving during a mem stall SHALL never be lost and SHALL produce exactly one flush cycle.
REQ-013 An internal counter SHALL track consecutive hazard-stall cycles (REQ-009 cycles only).
- It SHALL clear on any other cycle and saturate at MAX_STALL.
- When it reaches MAX_STALL, stall_timeout SHALL set and stay 1 until reset.
- Mem-stall cycles SHALL hold the counter, not clear it.
REQ-014 With no stall condition, all control outputs SHALL be 0.

Reset
REQ-015 rst_n=0 SHALL immediately force:
- state RUN and state_o=2'b00;
- the hazard counter and stall_timeout to 0;
- all statistics counters to 0.
Control outputs SHALL then follow REQ-005 from the RUN state. Reset asserted mid-stall SHALL discard any pending branch.

Configuration
REQ-016 Macro STALL_STATS_EN SHALL control the statistics counters.
- Defined: hazard_cnt SHALL count REQ-009 cycles, memwait_cnt SHALL count REQ-007 cycles, and flush_cnt SHALL count REQ-008/REQ-010 cycles.
- Each counter SHALL saturate at all-ones.
- Undefined: the three ports SHALL remain and be tied to 0, with no counter flops inferred.

Verification
REQ-017 Directed scenarios:
- Reset: rst_n=0 with hazard_Detected=1 -> state_o=00 and stall_timeout=0; with hazard_Detected=1 still applied, freeze_pc=1 per REQ-009/REQ-015.
- Hazard: hazard_Detected=1 for 3 cycles with MAX_STALL=8 -> freeze_pc, freeze_if_id and bubble_id_ex are 1 for exactly 3 cycles; stall_timeout=0; hazard_cnt=3 (STALL_STATS_EN).
- Timeout: hazard_Detected=1 for 10 cycles -> stall_timeout rises at the edge ending the 8th cycle and stays 1 after the hazard drops.
- Branch during mem stall: mem_ready=0 for 4 cycles with a branch_taken pulse in cycle 2 -> freeze_pipe=1 for 4 cycles and state_o=10 from cycle 3; in cycle 5 (mem_ready=1) flush_if_id=1 for exactly one cycle, then state_o=00; flush_cnt=1 and memwait_cnt=4.
- Priority: branch_taken=1 and hazard_Detected=1 together in RUN -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0.
- Reset mid-wait: assert rst_n=0 in MEM_WAIT_BR -> state_o=00 at once; no flush after release.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: mem stall, branch flush, RAW stall.
// Optional statistics counters are built when STALL_STATS_EN is defined.
module hazard_stall_ctrl #(
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_Detected,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_pipe,
  output logic             stall_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int HW = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    MEM_WAIT    = 2'b01,
    MEM_WAIT_BR = 2'b10,
    ILLEGAL     = 2'b11
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            ill;
  logic            br_pend;
  logic            is_mem;
  logic            is_flush;
  logic            is_hz;
  logic [HW-1:0]   hz_run;

  assign ill      = (state == ILLEGAL);
  assign br_pend  = (state == MEM_WAIT_BR);
  assign is_mem   = !ill && !mem_ready;
  assign is_flush = !ill && mem_ready
                 && (branch_taken || br_pend);
  assign is_hz    = !ill && mem_ready && !branch_taken
                 && !br_pend && hazard_Detected;

  assign freeze_pc    = is_mem | is_hz;
  assign freeze_if_id = is_mem | is_hz;
  assign flush_if_id  = is_flush;
  assign bubble_id_ex = is_flush | is_hz;
  assign freeze_pipe  = is_mem;
  assign state_o      = state;

  // A branch seen during a mem stall is parked in MEM_WAIT_BR.
  always_comb begin
    next_state = RUN;
    if (is_mem) begin
      if (branch_taken || br_pend) begin
        next_state = MEM_WAIT_BR;
      end else begin
        next_state = MEM_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Mem stalls hold the run length so a RAW deadlock is still caught.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_run        <= '0;
      stall_timeout <= 1'b0;
    end else if (is_hz) begin
      if (hz_run != HW'(MAX_STALL)) begin
        hz_run <= hz_run + HW'(1);
      end
      if (hz_run >= HW'(MAX_STALL - 1)) begin
        stall_timeout <= 1'b1;
      end
    end else if (!is_mem) begin
      hz_run <= '0;
    end
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_cnt  <= '0;
      memwait_cnt <= '0;
      flush_cnt   <= '0;
    end else begin
      if (is_hz && hazard_cnt != '1) begin
        hazard_cnt <= hazard_cnt + CNT_W'(1);
      end
      if (is_mem && memwait_cnt != '1) begin
        memwait_cnt <= memwait_cnt + CNT_W'(1);
      end
      if (is_flush && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign hazard_cnt  = '0;
  assign memwait_cnt = '0;
  assign flush_cnt   = '0;
`endif

endmodule
